cu_bus_reader: RTL and testbench
================================

# cu_bus_reader

Control-unit bus read sequencer: reads one or more words from the bank of 16-bit load-enabled datapath registers and presents them on the shared data bus with a valid/ready handshake. It sits between the register bank outputs and the bus, opposite the register load path: the registers capture from the bus on the falling edge, and this block sources the bus from them on the rising edge. It supports single reads and auto-incrementing bursts with index wrap-around.

## Interface

Parameters:
- WIDTH, 16, data word width.
- NREG, 8, number of registers in the bank.
- SELW, 3, register index width; NREG = 2**SELW.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- reg_bus  input  NREG*WIDTH  flattened register outputs; register i occupies bits [i*WIDTH +: WIDTH].
- rd_req  input  1  start request; sampled only in IDLE.
- rd_sel  input  SELW  start register index; captured with rd_req.
- burst_len  input  SELW  number of words minus one; 0 means one word. Captured with rd_req.
- bus_ready  input  1  consumer accepts the current word when high while bus_valid is high.
- bus_out  output  WIDTH  word driven to the bus.
- bus_valid  output  1  bus_out holds a valid word.
- busy  output  1  a transfer is in progress.
- done  output  1  one-cycle pulse after the last word is accepted.

## Operation

- States: IDLE, LATCH, DRIVE.
- Internal state: ptr (SELW bits) and remaining (SELW+1 bits, range 1..NREG).
- IDLE:
  - If rd_req=1: ptr<=rd_sel, remaining<=burst_len+1, busy<=1, go to LATCH.
  - Otherwise stay in IDLE.
- LATCH:
  - bus_out<=reg_bus word[ptr], bus_valid<=1, go to DRIVE.
- DRIVE, with bus_ready=0:
  - Hold bus_out and bus_valid stable; no state change.
- DRIVE, with bus_ready=1 (word accepted):
  - bus_valid<=0.
  - If remaining==1: busy<=0, done<=1, go to IDLE.
  - Otherwise: ptr<=ptr+1 (modulo NREG, so 7 wraps to 0), remaining<=remaining-1, go to LATCH.
- rd_req while busy is ignored. It is not queued.
- rd_sel and burst_len changes after capture have no effect on the current transfer.
- bus_out keeps its last value when bus_valid=0. The bus mux must not treat it as valid.
- Register contents are sampled at the LATCH edge:
  - A falling-edge load before that rising edge is visible.
  - Later loads do not alter the word being driven.
- Maximum burst is NREG words (burst_len = NREG-1), which visits every register exactly once.

## Timing

- Reset (synchronous, takes priority over everything):
  - Next edge forces state=IDLE, bus_out=0, bus_valid=0, busy=0, done=0, ptr=0, remaining=0.
  - Reset mid-transfer aborts it with no done pulse.
- rd_req sampled at edge k:
  - busy=1 after edge k.
  - bus_valid=1 after edge k+1.
  - The first word is on the bus 2 cycles after the request edge.
- Throughput with bus_ready held high: one word every 2 cycles (LATCH bubble).
- N-word burst with bus_ready always high:
  - Accepts at edges k+2, k+4, …, k+2N.
  - done=1 and busy=0 after edge k+2N, for exactly one cycle.
- done and busy:
  - done is never high at the same time as bus_valid.
  - done can coincide with a new rd_req being sampled; that request is accepted, because the state is already IDLE.
- bus_ready while bus_valid=0 is ignored.

## Test plan

- Single read:
  - Stimulus: reg3=0xBEEF; rd_req with rd_sel=3, burst_len=0; bus_ready=1.
  - Required: bus_out=0xBEEF, bus_valid high for 1 cycle, done pulses 1 cycle later, busy low afterwards.
- Wrap-around burst:
  - Stimulus: reg6=0x0006, reg7=0x0007, reg0=0x0000, reg1=0x0001; rd_sel=6, burst_len=3.
  - Required: words 0x0006, 0x0007, 0x0000, 0x0001 in order, done after the 4th accept.
- Backpressure:
  - Stimulus: bus_ready=0 for 5 cycles during word 2 of a 3-word burst.
  - Required: bus_out and bus_valid held stable; no ptr advance; burst completes correctly after ready returns.
- Full-bank burst:
  - Stimulus: rd_sel=0, burst_len=7, regs=0x1000+i.
  - Required: 8 words 0x1000..0x1007; done exactly once.
- Ignored request and reset:
  - Stimulus: rd_req pulsed mid-burst, then reset asserted during DRIVE.
  - Required: the extra request has no effect; after the reset edge all outputs are 0, the state is IDLE, and no done pulse occurs.
- Sample point:
  - Stimulus: load reg2 with 0x1234 on the falling edge just before the LATCH edge, then 0x5678 during DRIVE.
  - Required: bus_out=0x1234 for the whole DRIVE phase.

Source files
------------

// File: rtl/cu_bus_reader.sv
// rtl/cu_bus_reader.sv - bus read sequencer sourcing register bank words onto the shared data bus
module cu_bus_reader #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int SELW  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREG*WIDTH-1:0] reg_bus,
  input  logic                  rd_req,
  input  logic [SELW-1:0]       rd_sel,
  input  logic [SELW-1:0]       burst_len,
  input  logic                  bus_ready,
  output logic [WIDTH-1:0]      bus_out,
  output logic                  bus_valid,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [SELW:0]     remaining_q, remaining_d;
  logic [WIDTH-1:0]  bus_out_q, bus_out_d;
  logic              bus_valid_q, bus_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]  words [NREG];

  // Unflatten the register bank so the read mux can be indexed by ptr
  for (genvar g = 0; g < NREG; g++) begin : g_words
    assign words[g] = reg_bus[g*WIDTH +: WIDTH];
  end

  // Next-state and output decode; ptr wraps naturally at SELW bits
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    bus_out_d   = bus_out_q;
    bus_valid_d = bus_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          ptr_d       = rd_sel;
          remaining_d = {1'b0, burst_len} + (SELW+1)'(1);
          busy_d      = 1'b1;
          state_d     = ST_LATCH;
        end
      end
      ST_LATCH: begin
        // Word is frozen here; later register loads do not disturb the bus
        bus_out_d   = words[ptr_q];
        bus_valid_d = 1'b1;
        state_d     = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (bus_ready) begin
          bus_valid_d = 1'b0;
          if (remaining_q == (SELW+1)'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ptr_d       = ptr_q + SELW'(1);
            remaining_d = remaining_q - (SELW+1)'(1);
            state_d     = ST_LATCH;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        bus_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-high reset that aborts any transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      bus_out_q   <= bus_out_d;
      bus_valid_q <= bus_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus_out   = bus_out_q;
  assign bus_valid = bus_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_cu_bus_reader.sv
// tb/tb_cu_bus_reader.sv - self-checking bench for cu_bus_reader
module tb_cu_bus_reader;
  localparam int WIDTH = 16;
  localparam int NREG  = 8;
  localparam int SELW  = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREG*WIDTH-1:0] reg_bus;
  logic                  rd_req;
  logic [SELW-1:0]       rd_sel;
  logic [SELW-1:0]       burst_len;
  logic                  bus_ready;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;
  logic                  busy;
  logic                  done;

  logic [WIDTH-1:0]      regs_m [NREG];
  logic [WIDTH-1:0]      got_q [$];
  int                    checks = 0;
  int                    errors = 0;

  typedef struct {
    logic [WIDTH-1:0] base;
    logic [SELW-1:0]  sel;
    logic [SELW-1:0]  len;
    int               stall_word;
    int               stall_cyc;
    logic [WIDTH-1:0] exp_first;
    logic [WIDTH-1:0] exp_last;
    int               exp_cycles;
  } vec_t;

  vec_t vecs [6];

  cu_bus_reader #(.WIDTH(WIDTH), .NREG(NREG), .SELW(SELW)) dut (
    .clk       (clk),
    .reset     (reset),
    .reg_bus   (reg_bus),
    .rd_req    (rd_req),
    .rd_sel    (rd_sel),
    .burst_len (burst_len),
    .bus_ready (bus_ready),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always_comb begin
    reg_bus = '0;
    for (int i = 0; i < NREG; i++) reg_bus[i*WIDTH +: WIDTH] = regs_m[i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: an N-word burst from sel returns regs[(sel+i) mod NREG] in order
  task automatic check_words(input logic [SELW-1:0] sel, input logic [SELW-1:0] len);
    int n;
    n = int'(len) + 1;
    chk("word_count", got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got_q.size()) chk("word_data", got_q[i], regs_m[(int'(sel) + i) % NREG]);
    end
  endtask

  task automatic do_burst(input logic [SELW-1:0] sel, input logic [SELW-1:0] len, input int ready_pct,
                          input int stall_word, input int stall_cyc, input bit poke,
                          output int cyc_to_done, output int ndone, output int stalls);
    int cyc;
    int post;
    int stalled;
    logic pv;
    logic pr;
    logic [WIDTH-1:0] po;
    cyc = 0; post = 0; stalled = 0; pv = 1'b0; pr = 1'b0; po = '0;
    got_q.delete();
    ndone = 0; cyc_to_done = -1; stalls = 0;
    rd_req = 1'b1; rd_sel = sel; burst_len = len; bus_ready = 1'b0;
    @(posedge clk); #1;
    rd_req = 1'b0; rd_sel = SELW'($urandom); burst_len = SELW'($urandom);
    chk("busy_after_req", busy, 1);
    chk("valid_after_req", bus_valid, 0);
    while (cyc < 400 && !(ndone > 0 && post >= 3)) begin
      if (pv && !pr) begin
        chk("hold_valid", bus_valid, 1);
        chk("hold_data", bus_out, po);
      end
      if (bus_valid && got_q.size() == stall_word && stalled < stall_cyc) begin
        bus_ready = 1'b0;
        stalled++;
      end else begin
        bus_ready = ($urandom_range(0, 99) < ready_pct);
      end
      rd_req = poke && (cyc == 3);
      if (rd_req) begin
        rd_sel = SELW'($urandom);
        burst_len = SELW'($urandom);
      end
      if (bus_valid && bus_ready) got_q.push_back(bus_out);
      if (bus_valid && !bus_ready) stalls++;
      pv = bus_valid; pr = bus_ready; po = bus_out;
      @(posedge clk); #1;
      cyc++;
      if (ndone > 0) post++;
      if (done) begin
        ndone++;
        if (cyc_to_done < 0) cyc_to_done = cyc;
        chk("busy_at_done", busy, 0);
        chk("valid_at_done", bus_valid, 0);
      end
    end
    if (ndone == 0) chk("burst_timeout", 0, 1);
    rd_req = 1'b0;
    bus_ready = 1'b0;
  endtask

  initial begin
    int c, nd, st, pct;
    logic [SELW-1:0] s, l;

    vecs[0] = '{16'hBEEC, 3'd3, 3'd0, -1, 0, 16'hBEEF, 16'hBEEF, 2};
    vecs[1] = '{16'h0000, 3'd6, 3'd3, -1, 0, 16'h0006, 16'h0001, 8};
    vecs[2] = '{16'h1000, 3'd0, 3'd7, -1, 0, 16'h1000, 16'h1007, 16};
    vecs[3] = '{16'hA000, 3'd7, 3'd1, -1, 0, 16'hA007, 16'hA000, 4};
    vecs[4] = '{16'hA000, 3'd1, 3'd2, 1, 5, 16'hA001, 16'hA003, 11};
    vecs[5] = '{16'h5550, 3'd5, 3'd7, -1, 0, 16'h5555, 16'h5554, 16};

    reset = 1'b1; rd_req = 1'b0; rd_sel = '0; burst_len = '0; bus_ready = 1'b0;
    for (int i = 0; i < NREG; i++) regs_m[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_out", bus_out, 0);
    chk("rst_valid", bus_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < NREG; i++) regs_m[i] = vecs[v].base + WIDTH'(i);
      do_burst(vecs[v].sel, vecs[v].len, 100, vecs[v].stall_word, vecs[v].stall_cyc, 1'b0, c, nd, st);
      chk("vec_ndone", nd, 1);
      chk("vec_cycles", c, vecs[v].exp_cycles);
      if (got_q.size() > 0) begin
        chk("vec_first", got_q[0], vecs[v].exp_first);
        chk("vec_last", got_q[got_q.size()-1], vecs[v].exp_last);
      end
      check_words(vecs[v].sel, vecs[v].len);
    end

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREG; i++) regs_m[i] = WIDTH'($urandom);
      s = SELW'($urandom);
      l = SELW'($urandom);
      pct = $urandom_range(30, 100);
      do_burst(s, l, pct, -1, 0, (l >= 2), c, nd, st);
      chk("rnd_ndone", nd, 1);
      chk("rnd_cycles", c, 2 * (int'(l) + 1) + st);
      check_words(s, l);
    end

    // Sample point: a load just before the LATCH edge is seen, a later one is not
    for (int i = 0; i < NREG; i++) regs_m[i] = 16'h0100 + WIDTH'(i);
    rd_req = 1'b1; rd_sel = 3'd2; burst_len = 3'd0; bus_ready = 1'b0;
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
    regs_m[2] = 16'h1234;
    @(posedge clk); #1;
    chk("sp_valid", bus_valid, 1);
    chk("sp_first", bus_out, 16'h1234);
    @(negedge clk);
    regs_m[2] = 16'h5678;
    repeat (3) begin
      @(posedge clk); #1;
      chk("sp_hold", bus_out, 16'h1234);
      chk("sp_hold_valid", bus_valid, 1);
    end
    bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    chk("sp_done", done, 1);
    chk("sp_valid_low", bus_valid, 0);
    chk("sp_busy_low", busy, 0);
    chk("sp_out_kept", bus_out, 16'h1234);
    @(posedge clk); #1;
    chk("sp_done_pulse", done, 0);

    // Request sampled in the same cycle as done is accepted
    for (int i = 0; i < NREG; i++) regs_m[i] = 16'h2200 + WIDTH'(i);
    rd_req = 1'b1; rd_sel = 3'd1; burst_len = 3'd0; bus_ready = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(posedge clk); #1;
    chk("bb_valid1", bus_valid, 1);
    chk("bb_word1", bus_out, 16'h2201);
    @(posedge clk); #1;
    chk("bb_done1", done, 1);
    rd_req = 1'b1; rd_sel = 3'd4; burst_len = 3'd0;
    @(posedge clk); #1;
    rd_req = 1'b0;
    chk("bb_busy2", busy, 1);
    chk("bb_done_low", done, 0);
    @(posedge clk); #1;
    chk("bb_valid2", bus_valid, 1);
    chk("bb_word2", bus_out, 16'h2204);
    @(posedge clk); #1;
    chk("bb_done2", done, 1);
    bus_ready = 1'b0;
    @(posedge clk); #1;

    // Ignored request mid-burst, then reset during DRIVE
    for (int i = 0; i < NREG; i++) regs_m[i] = 16'h3300 + WIDTH'(i);
    rd_req = 1'b1; rd_sel = 3'd0; burst_len = 3'd7; bus_ready = 1'b0;
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(posedge clk); #1;
    chk("ir_valid", bus_valid, 1);
    rd_req = 1'b1; rd_sel = 3'd5; burst_len = 3'd0;
    @(posedge clk); #1;
    rd_req = 1'b0;
    chk("ir_data", bus_out, 16'h3300);
    chk("ir_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mr_bus_out", bus_out, 0);
    chk("mr_valid", bus_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    bus_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("mr_no_done", done, 0);
      chk("mr_idle_valid", bus_valid, 0);
      chk("mr_idle_busy", busy, 0);
    end
    bus_ready = 1'b0;

    regs_m[3] = 16'hC0DE;
    do_burst(3'd3, 3'd0, 100, -1, 0, 1'b0, c, nd, st);
    chk("post_rst_ndone", nd, 1);
    chk("post_rst_cycles", c, 2);
    check_words(3'd3, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
